// File: rtl/counter_16x_pkg.sv
// Shared 74xx-family chip definitions: direction encoding, width limit and the common bench assert macro.
`ifndef CHIP_ASSERT
`define CHIP_ASSERT(cond, msg) assert (cond) else $error(msg);
`endif

package counter_16x_pkg;
    localparam logic        DIR_UP        = 1'b1;
    localparam logic        DIR_DOWN      = 1'b0;
    localparam int unsigned CNT_MAX_WIDTH = 16;
endpackage

// File: rtl/counter_16x_tc.sv
// Terminal-count detector; flags are qualified by direction so they can feed rco directly.
module counter_16x_tc
    import counter_16x_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MODULO = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic             at_max,
    output logic             at_zero
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

    assign at_max  = (up == DIR_UP)   && (q == MAX_VAL);
    assign at_zero = (up == DIR_DOWN) && (q == '0);
endmodule

// File: rtl/counter_16x.sv
// Parametrised 74x160/161/163/169-style counter with sync clear/load, P/T enables and ripple carry.
// Optional macro COUNTER_16X_OE_EN adds an active-low output enable (oe_n) that tri-states q.
module counter_16x
    import counter_16x_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MODULO = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_n,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
`ifdef COUNTER_16X_OE_EN
    input  logic             oe_n,
`endif
    output logic [WIDTH-1:0] q,
    output logic             rco
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

    if (WIDTH < 1 || WIDTH > CNT_MAX_WIDTH || MODULO < 2 || MODULO > (32'd1 << WIDTH)) begin : g_bad_cfg
        $error("counter_16x: MODULO must be in 2..2^WIDTH and WIDTH in 1..16");
    end

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             at_max;
    logic             at_zero;
    logic             over;

    counter_16x_tc #(
        .WIDTH  (WIDTH),
        .MODULO (MODULO)
    ) u_tc (
        .q       (q_q),
        .up      (up),
        .at_max  (at_max),
        .at_zero (at_zero)
    );

    // Out-of-range values (only reachable by load) wrap like terminal count.
    assign over = (32'(q_q) >= MODULO);

    always_comb begin
        q_d = q_q;
        if (!load_n) begin
            q_d = d;
        end else if (enp && ent) begin
            if (up == DIR_UP) begin
                q_d = (at_max || over) ? '0 : q_q + 1'b1;
            end else begin
                q_d = (at_zero || over) ? MAX_VAL : q_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign rco = ent & (at_max | at_zero);

`ifdef COUNTER_16X_OE_EN
    assign q = oe_n ? 'z : q_q;
`else
    assign q = q_q;
`endif
endmodule

// File: tb/tb_counter_16x.sv
// Scoreboard bench for counter_16x: driver queues hand-computed expectations, negedge monitor checks them.
module tb_counter_16x;
    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } item_t;

    item_t sb[$];
    int    total = 0;
    int    bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: decade counter
    logic       rst_n, ld_n, enp, ent, up;
    logic [3:0] d, q;
    logic       rco;

    counter_16x #(.WIDTH(4), .MODULO(10)) u_dut (
        .clk(clk), .reset_n(rst_n), .load_n(ld_n), .enp(enp), .ent(ent), .up(up),
        .d(d),
`ifdef COUNTER_16X_OE_EN
        .oe_n(1'b0),
`endif
        .q(q), .rco(rco)
    );

    // Two-stage decade cascade
    logic       c_rst, c_ld, c_enp;
    logic [3:0] c_d0, c_d1, c_q0, c_q1;
    logic       c_rco0, c_rco1;

    counter_16x #(.WIDTH(4), .MODULO(10)) u_c0 (
        .clk(clk), .reset_n(c_rst), .load_n(c_ld), .enp(c_enp), .ent(1'b1), .up(1'b1),
        .d(c_d0),
`ifdef COUNTER_16X_OE_EN
        .oe_n(1'b0),
`endif
        .q(c_q0), .rco(c_rco0)
    );

    counter_16x #(.WIDTH(4), .MODULO(10)) u_c1 (
        .clk(clk), .reset_n(c_rst), .load_n(c_ld), .enp(c_enp), .ent(c_rco0), .up(1'b1),
        .d(c_d1),
`ifdef COUNTER_16X_OE_EN
        .oe_n(1'b0),
`endif
        .q(c_q1), .rco(c_rco1)
    );

    int         incs = 0;
    int         inc_base = 0;
    logic [3:0] q1_prev = 4'hx;
    always @(posedge clk) begin
        #1;
        if (c_q1 !== q1_prev) incs++;
        q1_prev = c_q1;
    end

`ifdef COUNTER_16X_OE_EN
    logic       o_rst, o_ld, o_enp, o_oe_n;
    logic [7:0] o_d, o_q;
    logic       o_rco;

    counter_16x #(.WIDTH(8), .MODULO(256)) u_oe (
        .clk(clk), .reset_n(o_rst), .load_n(o_ld), .enp(o_enp), .ent(1'b1), .up(1'b1),
        .d(o_d), .oe_n(o_oe_n), .q(o_q), .rco(o_rco)
    );
`endif

    function automatic logic [15:0] actual(int sel);
        logic [15:0] a;
        a = '0;
        case (sel)
            0: a = {11'd0, rco, q};
            1: a = {8'd0, c_q1, c_q0};
            2: a = 16'(incs - inc_base);
`ifdef COUNTER_16X_OE_EN
            3: a = {7'd0, o_rco, o_q};
`endif
            default: a = 16'hxxxx;
        endcase
        return a;
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            item_t it;
            logic [15:0] act;
            it  = sb.pop_front();
            act = actual(it.sel);
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    end

    task automatic push(input string n, input int sel, input logic [15:0] e);
        item_t it;
        it.name = n;
        it.sel  = sel;
        it.exp  = e;
        sb.push_back(it);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic main_step(input logic r, input logic l, input logic p, input logic t,
                             input logic u, input logic [3:0] dd, input string n,
                             input logic [3:0] eq, input logic er);
        rst_n = r; ld_n = l; enp = p; ent = t; up = u; d = dd;
        @(posedge clk);
        push(n, 0, {11'd0, er, eq});
        settle();
    endtask

    initial begin
        rst_n = 1'b0; ld_n = 1'b1; enp = 1'b0; ent = 1'b0; up = 1'b1; d = '0;
        c_rst = 1'b0; c_ld = 1'b1; c_enp = 1'b0; c_d0 = '0; c_d1 = '0;
`ifdef COUNTER_16X_OE_EN
        o_rst = 1'b0; o_ld = 1'b1; o_enp = 1'b0; o_oe_n = 1'b1; o_d = '0;
`endif

        //          rst  ld  enp ent up  d      name             q     rco
        main_step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7, "reset_over_load", 4'd0, 1'b0);
        main_step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7, "load7",           4'd7, 1'b0);
        main_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, "load8",           4'd8, 1'b0);
        main_step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, "up_to9_rco",      4'd9, 1'b1);
        main_step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, "up_wrap0",        4'd0, 1'b0);
        main_step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd9, "load9",           4'd9, 1'b1);
        main_step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, "ent0_hold9",      4'd9, 1'b0);
        main_step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, "ent0_hold9b",     4'd9, 1'b0);
        main_step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, "load1_down",      4'd1, 1'b0);
        main_step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "down_to0_rco",    4'd0, 1'b1);
        main_step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "down_wrap9",      4'd9, 1'b0);
        main_step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "down_to8",        4'd8, 1'b0);
        main_step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd12, "load12",         4'd12, 1'b0);
        main_step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "down_over_to9",   4'd9, 1'b0);
        main_step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd12, "load12_up",      4'd12, 1'b0);
        main_step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, "up_over_to0",     4'd0, 1'b0);
        main_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, "load4",           4'd4, 1'b0);

        for (int k = 0; k < 3; k++) begin
            logic [1:0] pt;
            pt = 2'(k);
            for (int c = 0; c < 3; c++) begin
                main_step(1'b1, 1'b1, pt[1], pt[0], 1'b1, 4'd0, $sformatf("en_hold_%0d%0d", pt[1], pt[0]), 4'd4, 1'b0);
            end
        end
        main_step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, "en_11_adv",       4'd5, 1'b0);
        main_step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "reset_down_rco",  4'd0, 1'b1);

        // Cascade: reset, then count 100 edges
        c_rst = 1'b0;
        @(posedge clk);
        settle();
        c_rst = 1'b1;
        inc_base = incs;
        c_enp = 1'b1;
        repeat (37) @(posedge clk);
        push("casc_37", 1, 16'h0037);
        settle();
        repeat (63) @(posedge clk);
        push("casc_100", 1, 16'h0000);
        push("casc_incs", 2, 16'd10);
        settle();
        c_enp = 1'b0; c_ld = 1'b0; c_d0 = 4'd9; c_d1 = 4'd9;
        @(posedge clk);
        push("casc_load99", 1, 16'h0099);
        settle();
        c_ld = 1'b1; c_enp = 1'b1;
        @(posedge clk);
        push("casc_wrap00", 1, 16'h0000);
        settle();

`ifdef COUNTER_16X_OE_EN
        o_rst = 1'b0;
        @(posedge clk);
        settle();
        o_rst = 1'b1; o_enp = 1'b1; o_oe_n = 1'b1;
        repeat (3) @(posedge clk);
        push("oe_hiz", 3, {7'd0, 1'b0, 8'bzzzzzzzz});
        settle();
        o_enp = 1'b0; o_oe_n = 1'b0;
        #1;
        push("oe_drive3", 3, {7'd0, 1'b0, 8'd3});
        settle();
        o_ld = 1'b0; o_d = 8'd255;
        @(posedge clk);
        push("oe_rco255", 3, {7'd0, 1'b1, 8'd255});
        settle();
`endif

        repeat (2) settle();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
